alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_op  input  2  ALU operation code.
REQ-007 cmd_a  input  16  first operand.
REQ-008 cmd_b  input  16  second operand.
REQ-009 alu_op  output  2  registered op driven to external combinational ALU.
REQ-010 alu_i0  output  16  registered first operand to ALU.
REQ-011 alu_i1  output  16  registered second operand to ALU.
REQ-012 alu_o  input  16  ALU result.
REQ-013 alu_cout  input  1  ALU carry/borrow out.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  16  captured alu_o.
REQ-017 res_cout  output  1  captured alu_cout.
REQ-018 res_op  output  2  op that produced the result.
REQ-019 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-020 op_count  output  16  completed-result counter.

Function
REQ-021 Command accepted on a rising edge where cmd_valid && cmd_ready; {cmd_op, cmd_a, cmd_b} pushed to FIFO tail.
REQ-022 cmd_ready SHALL equal !full from registered FIFO count; no same-cycle pop bypass (full FIFO stays not-ready even if popping that cycle).
REQ-023 FSM states: IDLE, ISSUE, HOLD.
REQ-024 IDLE: if FIFO non-empty at edge -> ISSUE, loading alu_op/alu_i0/alu_i1 from FIFO head; else stay.
REQ-025 ISSUE (exactly one cycle): at next edge capture alu_o->res_data, alu_cout->res_cout, alu_op->res_op, pop FIFO head, set res_valid=1, -> HOLD.
REQ-026 HOLD: res_valid held, res_data/res_cout/res_op stable until res_valid && res_ready at an edge.
REQ-027 On HOLD handshake: res_valid->0, op_count increments; if FIFO non-empty (after pop done in ISSUE) -> ISSUE loading new head, else -> IDLE.
REQ-028 Latency: command accepted at edge N into empty idle block -> alu ports updated at N+1 -> res_valid=1 after edge N+2.
REQ-029 Throughput with res_ready tied high and FIFO kept non-empty: one result per 2 cycles.
REQ-030 alu_* outputs hold last issued values in IDLE/HOLD; only change when entering ISSUE.
REQ-031 Simultaneous push and pop at same edge: count unchanged, both take effect, ordering FIFO-preserved.
REQ-032 FIFO pointers wrap modulo DEPTH; push when full and pop when empty never occur (guarded).
REQ-033 op_count wraps 16'hffff -> 16'h0000.
REQ-034 Results leave in command acceptance order; no command dropped or duplicated.

Reset
REQ-035 reset asserted SHALL immediately (asynchronously) force: state IDLE, FIFO empty, cmd_ready=1, res_valid=0, res_data=0, res_cout=0, res_op=0, alu_op=0, alu_i0=0, alu_i1=0, op_count=0, busy=0.
REQ-036 Reset mid-operation (ISSUE or HOLD, FIFO non-empty) discards all pending commands and any held result; no result emitted after release until new command accepted.
REQ-037 After reset deasserts, first command accepted on first rising edge with cmd_valid high.

Verification (bench ALU model: op 00 = 16-bit add, cout = carry)
REQ-038 Single command: op 00, a=16'haa55, b=16'h55aa, res_ready=1 -> res_valid 2 edges after accept, res_data=16'hffff, res_cout=0, op_count=1.
REQ-039 Carry: op 00, a=16'hffff, b=16'h0001 -> res_data=16'h0000, res_cout=1, res_op=2'b00.
REQ-040 Backpressure/full: res_ready=0, push DEPTH+1 commands back-to-back -> cmd_ready falls once FIFO full; first result held stable in HOLD; release res_ready -> all results emerge in order, op_count=DEPTH+1.
REQ-041 Streaming: 8 commands with cmd_valid and res_ready held high -> results every 2 cycles, in order, correct sums.
REQ-042 Reset mid-HOLD with 3 queued commands -> all outputs zero immediately, busy=0, no stale result after release.
REQ-043 op_count wrap: preload via 65536 completions (or forced) -> op_count 16'hffff then 16'h0000.

Source files
------------

// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - command, external-ALU and result bus of the ALU driver
interface alu_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_i0;
    logic [15:0] alu_i1;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_cout;
    logic [1:0]  res_op;
    logic        busy;
    logic [15:0] op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_o, alu_cout, res_ready,
        output cmd_ready, alu_op, alu_i0, alu_i1, res_valid, res_data, res_cout,
               res_op, busy, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_o, alu_cout, res_ready,
        input  cmd_ready, alu_op, alu_i0, alu_i1, res_valid, res_data, res_cout,
               res_op, busy, op_count
    );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - queues ALU commands, drives an external combinational ALU
// and returns captured results in acceptance order.
module alu_driver #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    alu_driver_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    state_t          state_q;
    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [1:0]      alu_op_q;
    logic [15:0]     alu_i0_q;
    logic [15:0]     alu_i1_q;
    logic            res_valid_q;
    logic [15:0]     res_data_q;
    logic            res_cout_q;
    logic [1:0]      res_op_q;
    logic [15:0]     op_count_q;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    cmd_t            head;

    // Ready comes only from the registered count, so a full FIFO stays closed
    // even on the cycle its head is being popped.
    assign bus.cmd_ready = (count_q != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == ISSUE);
    assign fifo_empty    = (count_q == '0);
    assign head          = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_op_q    <= '0;
            alu_i0_q    <= '0;
            alu_i1_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_op_q    <= '0;
            op_count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_op_q <= head.op;
                        alu_i0_q <= head.a;
                        alu_i1_q <= head.b;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data_q  <= bus.alu_o;
                    res_cout_q  <= bus.alu_cout;
                    res_op_q    <= alu_op_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        // The head was already popped in ISSUE, so count_q is current.
                        if (!fifo_empty) begin
                            alu_op_q <= head.op;
                            alu_i0_q <= head.a;
                            alu_i1_q <= head.b;
                            state_q  <= ISSUE;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_op    = alu_op_q;
    assign bus.alu_i0    = alu_i0_q;
    assign bus.alu_i1    = alu_i1_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_op    = res_op_q;
    assign bus.op_count  = op_count_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with an external ALU
// model and an in-order result queue.
module tb_alu_driver;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [18:0] exp_q[$];
    logic [15:0] exp_count = '0;

    alu_driver_if bus();

    alu_driver #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // op 00 add, 01 sub (cout = borrow), 10 and, 11 xor; returns {cout, data}
    function automatic logic [16:0] alu_ref(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {bus.alu_cout, bus.alu_o} = alu_ref(bus.alu_op, bus.alu_i0, bus.alu_i1);

    task automatic new_cmd();
        bus.cmd_op = 2'($urandom_range(3));
        bus.cmd_a  = 16'($urandom);
        bus.cmd_b  = 16'($urandom);
    endtask

    // Samples both handshakes at the negedge, advances one clock, returns at the next negedge.
    task automatic step(output bit acc, output bit done, output logic [15:0] d,
                        output logic c, output logic [1:0] o);
        acc  = bus.cmd_valid && bus.cmd_ready;
        done = bus.res_valid && bus.res_ready;
        d    = bus.res_data;
        c    = bus.res_cout;
        o    = bus.res_op;
        if (acc) exp_q.push_back({bus.cmd_op, alu_ref(bus.cmd_op, bus.cmd_a, bus.cmd_b)});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.res_valid, bus.busy} !== 3'b100)
            begin errors++; $display("FAIL reset_flags got %b want 100", {bus.cmd_ready, bus.res_valid, bus.busy}); end
        checks++;
        if ({bus.res_data, bus.res_cout, bus.res_op} !== 19'd0)
            begin errors++; $display("FAIL reset_result got %h want 0", {bus.res_data, bus.res_cout, bus.res_op}); end
        checks++;
        if ({bus.alu_op, bus.alu_i0, bus.alu_i1} !== 34'd0)
            begin errors++; $display("FAIL reset_alu got %h want 0", {bus.alu_op, bus.alu_i0, bus.alu_i1}); end
        checks++;
        if (bus.op_count !== 16'd0)
            begin errors++; $display("FAIL reset_op_count got %h want 0", bus.op_count); end
        reset = 1'b0;
    endtask

    task automatic test_single(input string name, input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] exp_d, input logic exp_c);
        bit acc, done;
        logic [15:0] d;
        logic c;
        logic [1:0] o;
        logic [18:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.res_ready = 1'b1;
        step(acc, done, d, c, o);
        bus.cmd_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept got %b want 1", name, acc); end
        checks++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s_n0_valid got %b want 0", name, bus.res_valid); end
        step(acc, done, d, c, o);
        checks++;
        if ({bus.res_valid, bus.alu_op, bus.alu_i0, bus.alu_i1} !== {1'b0, op, a, b})
            begin errors++; $display("FAIL %s_n1_alu got %h want %h", name,
                {bus.res_valid, bus.alu_op, bus.alu_i0, bus.alu_i1}, {1'b0, op, a, b}); end
        step(acc, done, d, c, o);
        checks++;
        if ({bus.res_valid, bus.res_op, bus.res_cout, bus.res_data} !== {1'b1, op, exp_c, exp_d})
            begin errors++; $display("FAIL %s_n2_result got %h want %h", name,
                {bus.res_valid, bus.res_op, bus.res_cout, bus.res_data}, {1'b1, op, exp_c, exp_d}); end
        step(acc, done, d, c, o);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (done) exp_count++;
        checks++;
        if (!done || {o, c, d} !== exp)
            begin errors++; $display("FAIL %s_handshake got done=%b %h want %h", name, done, {o, c, d}, exp); end
        checks++;
        if ({bus.op_count, bus.res_valid, bus.busy} !== {exp_count, 2'b00})
            begin errors++; $display("FAIL %s_after got %h want %h", name,
                {bus.op_count, bus.res_valid, bus.busy}, {exp_count, 2'b00}); end
    endtask

    task automatic test_backpressure();
        bit acc, done, pending;
        logic [15:0] d, held;
        logic c;
        logic [1:0] o;
        logic [18:0] exp;
        int n, guard;
        n = 0;
        pending = 1'b0;
        bus.res_ready = 1'b0;
        for (guard = 0; guard < 30 && n < DEPTH + 1; guard++) begin
            if (!pending) new_cmd();
            bus.cmd_valid = 1'b1;
            step(acc, done, d, c, o);
            pending = !acc;
            if (acc) n++;
        end
        checks++;
        if (n != DEPTH + 1) begin errors++; $display("FAIL bp_accepted got %0d want %0d", n, DEPTH + 1); end
        new_cmd();
        held = exp_q[0][15:0];
        for (int i = 0; i < 4; i++) begin
            step(acc, done, d, c, o);
            checks++;
            if ({bus.cmd_ready, bus.res_valid, bus.res_data} !== {2'b01, held})
                begin errors++; $display("FAIL bp_hold got %h want %h", {bus.cmd_ready, bus.res_valid, bus.res_data}, {2'b01, held}); end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (guard = 0; guard < 40 && exp_q.size() != 0; guard++) begin
            step(acc, done, d, c, o);
            if (done) begin
                exp = exp_q.pop_front();
                exp_count++;
                checks++;
                if ({o, c, d} !== exp) begin errors++; $display("FAIL bp_order got %h want %h", {o, c, d}, exp); end
            end
        end
        checks++;
        if (exp_q.size() != 0 || bus.op_count !== exp_count)
            begin errors++; $display("FAIL bp_drain left=%0d op_count got %h want %h", exp_q.size(), bus.op_count, exp_count); end
    endtask

    task automatic test_stream();
        bit acc, done, pending;
        logic [15:0] d;
        logic c;
        logic [1:0] o;
        logic [18:0] exp;
        int sent, got, last, t;
        sent = 0; got = 0; last = 0; pending = 1'b0;
        bus.res_ready = 1'b1;
        for (int guard = 0; guard < 60 && got < 8; guard++) begin
            if (sent < 8) begin
                if (!pending) new_cmd();
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            t = cyc;
            step(acc, done, d, c, o);
            pending = (sent < 8) && !acc;
            if (acc) sent++;
            if (done) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                exp_count++;
                checks++;
                if ({o, c, d} !== exp) begin errors++; $display("FAIL stream_data got %h want %h", {o, c, d}, exp); end
                if (got > 0) begin
                    checks++;
                    if (t - last != 2) begin errors++; $display("FAIL stream_interval got %0d want 2", t - last); end
                end
                last = t;
                got++;
            end
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (got != 8 || bus.op_count !== exp_count)
            begin errors++; $display("FAIL stream_count got %0d/%h want 8/%h", got, bus.op_count, exp_count); end
    endtask

    task automatic test_random();
        bit acc, done, pending;
        logic [15:0] d;
        logic c;
        logic [1:0] o;
        logic [18:0] exp;
        int sent;
        sent = 0; pending = 1'b0;
        for (int guard = 0; guard < 2000 && (sent < 40 || exp_q.size() != 0); guard++) begin
            if (sent < 40) begin
                if (!pending) begin
                    new_cmd();
                    bus.cmd_valid = ($urandom_range(9) < 7);
                end
            end else begin
                bus.cmd_valid = 1'b0;
            end
            bus.res_ready = ($urandom_range(1) == 1);
            step(acc, done, d, c, o);
            pending = bus.cmd_valid && !acc;
            if (acc) sent++;
            if (done) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                exp_count++;
                checks++;
                if ({o, c, d} !== exp) begin errors++; $display("FAIL random_data got %h want %h", {o, c, d}, exp); end
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        checks++;
        if (sent != 40 || exp_q.size() != 0 || bus.op_count !== exp_count)
            begin errors++; $display("FAIL random_end sent=%0d left=%0d op_count got %h want %h", sent, exp_q.size(), bus.op_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        bit acc, done, pending;
        logic [15:0] d;
        logic c;
        logic [1:0] o;
        int n, stale;
        n = 0; pending = 1'b0; stale = 0;
        bus.res_ready = 1'b0;
        for (int guard = 0; guard < 20 && n < 4; guard++) begin
            if (!pending) new_cmd();
            bus.cmd_valid = 1'b1;
            step(acc, done, d, c, o);
            pending = !acc;
            if (acc) n++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (n != 4 || bus.res_valid !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL rstmid_setup got n=%0d valid=%b busy=%b want 4/1/1", n, bus.res_valid, bus.busy); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.res_valid, bus.busy, bus.res_data, bus.res_cout, bus.res_op} !== {3'b100, 19'd0})
            begin errors++; $display("FAIL rstmid_async got %h want %h",
                {bus.cmd_ready, bus.res_valid, bus.busy, bus.res_data, bus.res_cout, bus.res_op}, {3'b100, 19'd0}); end
        checks++;
        if ({bus.alu_op, bus.alu_i0, bus.alu_i1, bus.op_count} !== 50'd0)
            begin errors++; $display("FAIL rstmid_alu got %h want 0", {bus.alu_op, bus.alu_i0, bus.alu_i1, bus.op_count}); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_count = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(acc, done, d, c, o);
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d cycles active want 0", stale); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count_q = 16'hfffe;
        #1 release dut.op_count_q;
        exp_count = 16'hfffe;
        checks++;
        if (bus.op_count !== 16'hfffe) begin errors++; $display("FAIL wrap_preload got %h want fffe", bus.op_count); end
        @(negedge clk);
        test_single("wrap_ffff", 2'd1, 16'h0005, 16'h0007, 16'hfffe, 1'b1);
        test_single("wrap_0000", 2'd2, 16'hf0f0, 16'hff00, 16'hf000, 1'b0);
        checks++;
        if (bus.op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", bus.op_count); end
    endtask

    initial begin
        test_reset();
        test_single("single", 2'd0, 16'haa55, 16'h55aa, 16'hffff, 1'b0);
        test_single("carry", 2'd0, 16'hffff, 16'h0001, 16'h0000, 1'b1);
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
        test_single("post_reset", 2'd3, 16'h1234, 16'h00ff, 16'h12cb, 1'b0);
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
